// File: rtl/axi4_lite_arb_pkg.sv
// Shared types for the two-port AXI4-Lite master arbiter.
package axi4_lite_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // PORT_INSTR is port 0 (instruction fetch), PORT_DATA is port 1 (data access).
  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } arb_port_t;

endpackage

// File: rtl/axi4_lite_arbiter_rr.sv
// Two-way round-robin pick. On a tie the port that did not win last time is chosen.
module rr_arbiter_2
  import axi4_lite_arb_pkg::*;
(
  input  logic      req0_i,
  input  logic      req1_i,
  input  arb_port_t last_grant_i,
  output logic      grant_valid_o,
  output arb_port_t grant_port_o
);

  // Pure combinational priority: single requester wins outright, tie goes opposite last_grant.
  always_comb begin
    grant_valid_o = req0_i | req1_i;
    grant_port_o  = PORT_INSTR;
    if (req0_i && req1_i) begin
      grant_port_o = (last_grant_i == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
    end else if (req1_i) begin
      grant_port_o = PORT_DATA;
    end
  end

endmodule

// File: rtl/axi4_lite_arbiter.sv
// Shares one single-outstanding AXI4-Lite master between port 0 (fetch) and port 1 (data).
//
// Requester handshake: a port raises i_pN_req with we/addr/wdata stable and holds it until
// o_pN_done pulses for one cycle (rdata/fault valid in that cycle only). Request fields are
// latched at grant, so they may change once granted. Master handshake: one-cycle start pulse
// with o_m_addr/o_m_data held stable until i_m_done; i_m_done is only honoured in WAIT.
// o_dbg_state exposes the FSM state for observation.
module axi4_lite_arbiter
  import axi4_lite_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_p0_req,
  input  logic                  i_p0_we,
  input  logic [ADDR_WIDTH-1:0] i_p0_addr,
  input  logic [DATA_WIDTH-1:0] i_p0_wdata,
  output logic [DATA_WIDTH-1:0] o_p0_rdata,
  output logic                  o_p0_done,
  output logic                  o_p0_fault,
  input  logic                  i_p1_req,
  input  logic                  i_p1_we,
  input  logic [ADDR_WIDTH-1:0] i_p1_addr,
  input  logic [DATA_WIDTH-1:0] i_p1_wdata,
  output logic [DATA_WIDTH-1:0] o_p1_rdata,
  output logic                  o_p1_done,
  output logic                  o_p1_fault,
  output logic [ADDR_WIDTH-1:0] o_m_addr,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_start_write,
  output logic                  o_m_start_read,
  input  logic [DATA_WIDTH-1:0] i_m_data,
  input  logic                  i_m_write_fault,
  input  logic                  i_m_read_fault,
  input  logic                  i_m_done,
  output logic [1:0]            o_dbg_state
);

  arb_state_t            state_q;
  arb_port_t             owner_q;
  arb_port_t             last_grant_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  start_w_q;
  logic                  start_r_q;
  logic                  p0_done_q;
  logic                  p1_done_q;
  logic                  p0_fault_q;
  logic                  p1_fault_q;

  logic                  grant_valid;
  arb_port_t             grant_port;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  m_fault;

  rr_arbiter_2 u_rr (
    .req0_i        (i_p0_req),
    .req1_i        (i_p1_req),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_port_o  (grant_port)
  );

  // Request fields of the port being granted this cycle.
  assign sel_we    = (grant_port == PORT_DATA) ? i_p1_we    : i_p0_we;
  assign sel_addr  = (grant_port == PORT_DATA) ? i_p1_addr  : i_p0_addr;
  assign sel_wdata = (grant_port == PORT_DATA) ? i_p1_wdata : i_p0_wdata;

  // Only the fault flag matching the latched direction counts.
  assign m_fault = we_q ? i_m_write_fault : i_m_read_fault;

  // Arbitration FSM with every output registered; start/done/fault are one-cycle pulses.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q      <= IDLE;
      owner_q      <= PORT_INSTR;
      last_grant_q <= PORT_DATA;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      start_w_q    <= 1'b0;
      start_r_q    <= 1'b0;
      p0_done_q    <= 1'b0;
      p1_done_q    <= 1'b0;
      p0_fault_q   <= 1'b0;
      p1_fault_q   <= 1'b0;
    end else begin
      start_w_q  <= 1'b0;
      start_r_q  <= 1'b0;
      p0_done_q  <= 1'b0;
      p1_done_q  <= 1'b0;
      p0_fault_q <= 1'b0;
      p1_fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            owner_q   <= grant_port;
            we_q      <= sel_we;
            addr_q    <= sel_addr;
            wdata_q   <= sel_wdata;
            start_w_q <= sel_we;
            start_r_q <= ~sel_we;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (i_m_done) begin
            rdata_q      <= i_m_data;
            last_grant_q <= owner_q;
            if (owner_q == PORT_DATA) begin
              p1_done_q  <= 1'b1;
              p1_fault_q <= m_fault;
            end else begin
              p0_done_q  <= 1'b1;
              p0_fault_q <= m_fault;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          // Gives the requester a cycle to drop req before the next arbitration.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_m_addr        = addr_q;
  assign o_m_data        = wdata_q;
  assign o_m_start_write = start_w_q;
  assign o_m_start_read  = start_r_q;
  assign o_p0_rdata      = rdata_q;
  assign o_p1_rdata      = rdata_q;
  assign o_p0_done       = p0_done_q;
  assign o_p1_done       = p1_done_q;
  assign o_p0_fault      = p0_fault_q;
  assign o_p1_fault      = p1_fault_q;
  assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Bench for axi4_lite_arbiter: behavioural master model plus expected-completion queue.
module tb_axi4_lite_arbiter;
  import axi4_lite_arb_pkg::*;

  localparam int AW = 64;
  localparam int DW = 32;
  // Expected entry: {port, we, fault, addr, wdata, rdata}
  localparam int EW = 3 + AW + 2 * DW;
  // Master response entry: {write_fault, read_fault, rdata}
  localparam int RW = 2 + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr, m_addr;
  logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, m_data;
  logic          p0_done, p0_fault, p1_done, p1_fault;
  logic          m_sw, m_sr;
  logic [DW-1:0] m_rdata_in = '0;
  logic          m_wf = 1'b0, m_rf = 1'b0;
  logic          m_done;
  logic [1:0]    dbg_state;

  axi4_lite_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .arst            (arst),
    .i_p0_req        (p0_req),
    .i_p0_we         (p0_we),
    .i_p0_addr       (p0_addr),
    .i_p0_wdata      (p0_wdata),
    .o_p0_rdata      (p0_rdata),
    .o_p0_done       (p0_done),
    .o_p0_fault      (p0_fault),
    .i_p1_req        (p1_req),
    .i_p1_we         (p1_we),
    .i_p1_addr       (p1_addr),
    .i_p1_wdata      (p1_wdata),
    .o_p1_rdata      (p1_rdata),
    .o_p1_done       (p1_done),
    .o_p1_fault      (p1_fault),
    .o_m_addr        (m_addr),
    .o_m_data        (m_data),
    .o_m_start_write (m_sw),
    .o_m_start_read  (m_sr),
    .i_m_data        (m_rdata_in),
    .i_m_write_fault (m_wf),
    .i_m_read_fault  (m_rf),
    .i_m_done        (m_done),
    .o_dbg_state     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [RW-1:0] resp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- master model ----------------
  int            m_lat = 3;
  logic          model_done = 1'b0;
  logic          stale_done = 1'b0;
  bit            pending = 0;
  int            cnt = 0;
  logic [RW-1:0] cur_resp = '0;
  int            start_cnt = 0, p0_done_cnt = 0, p1_done_cnt = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;
  logic          last_we = 1'b0;
  int            start_cyc = 0;

  assign m_done = model_done | stale_done;

  always @(negedge clk) begin
    model_done = 1'b0;
    if (arst) begin
      pending = 0;
    end else begin
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          model_done = 1'b1;
          pending = 0;
          {m_wf, m_rf, m_rdata_in} = cur_resp;
        end
      end
      if (m_sw || m_sr) begin
        start_cnt++;
        last_addr = m_addr;
        last_data = m_data;
        last_we   = m_sw;
        start_cyc = cyc;
        pending   = 1;
        cnt       = m_lat;
        cur_resp  = (resp_q.size() > 0) ? resp_q.pop_front() : '0;
      end
    end
    if (p0_done) p0_done_cnt++;
    if (p1_done) p1_done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input bit port, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input bit wf, input bit rf,
                           input logic [DW-1:0] rdata);
    bit fault;
    fault = we ? wf : rf;
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end
    exp_q.push_back({port, we, fault, addr, wdata, rdata});
    resp_q.push_back({wf, rf, rdata});
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst = 1'b1;
    p0_req = 1'b0; p1_req = 1'b0;
    idle_cycles(2);
    arst = 1'b0;
    exp_q.delete();
    resp_q.delete();
    @(negedge clk);
  endtask

  // Waits (bounded) for a done pulse on either port, pops the expected entry and compares.
  task automatic wait_done(output int dcyc);
    bit            seen;
    bit            aport;
    logic [EW-1:0] e;
    logic [DW-1:0] act_rdata;
    logic          act_fault, oth_done, oth_fault;
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (p0_done || p1_done) seen = 1;
    end
    dcyc = cyc;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no done in 200 cycles, expected one");
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_done: p0_done=%0b p1_done=%0b with empty expected queue",
               p0_done, p1_done);
    end else begin
      e = exp_q.pop_front();
      aport     = p1_done;
      act_rdata = aport ? p1_rdata : p0_rdata;
      act_fault = aport ? p1_fault : p0_fault;
      oth_done  = aport ? p0_done  : p1_done;
      oth_fault = aport ? p0_fault : p1_fault;
      if (aport !== e[EW-1]) begin
        errors++;
        $display("FAIL done_port: got port %0d, expected port %0d", aport, e[EW-1]);
      end
      checks++;
      if (act_rdata !== e[DW-1:0]) begin
        errors++;
        $display("FAIL rdata: got %h, expected %h", act_rdata, e[DW-1:0]);
      end
      checks++;
      if (act_fault !== e[EW-3]) begin
        errors++;
        $display("FAIL fault: got %0b, expected %0b", act_fault, e[EW-3]);
      end
      checks++;
      if (oth_done !== 1'b0 || oth_fault !== 1'b0) begin
        errors++;
        $display("FAIL non_owner: got done=%0b fault=%0b, expected 0/0", oth_done, oth_fault);
      end
      checks++;
      if (last_addr !== e[2*DW+AW-1:2*DW]) begin
        errors++;
        $display("FAIL m_addr: got %h, expected %h", last_addr, e[2*DW+AW-1:2*DW]);
      end
      checks++;
      if (last_we !== e[EW-2]) begin
        errors++;
        $display("FAIL m_dir: got write=%0b, expected write=%0b", last_we, e[EW-2]);
      end
      checks++;
      if (last_data !== e[2*DW-1:DW]) begin
        errors++;
        $display("FAIL m_data: got %h, expected %h", last_data, e[2*DW-1:DW]);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    arst = 1'b1;
    p0_req = 1'b0; p1_req = 1'b0;
    idle_cycles(2);
    checks++;
    if ({p0_rdata, p0_done, p0_fault, p1_rdata, p1_done, p1_fault, m_addr, m_data, m_sw, m_sr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got m_addr=%h m_data=%h starts=%0b%0b dones=%0b%0b, expected all 0",
               m_addr, m_data, m_sw, m_sr, p0_done, p1_done);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, expected %0d", dbg_state, IDLE);
    end
    arst = 1'b0;
    idle_cycles(3);
    checks++;
    if (m_sw !== 1'b0 || m_sr !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL idle_no_req: got start=%0b%0b state=%0d, expected 00 and IDLE", m_sw, m_sr, dbg_state);
    end
  endtask

  task automatic test_single_read();
    int s, d0, d1, rc, dc;
    s = start_cnt; d0 = p0_done_cnt; d1 = p1_done_cnt;
    m_lat = 3;
    @(negedge clk);
    rc = cyc;
    drive_req(1'b0, 1'b0, 64'h1000, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF);
    wait_done(dc);
    p0_req = 1'b0;
    checks++;
    if (start_cyc !== rc + 1) begin
      errors++;
      $display("FAIL issue_latency: got start cycle %0d, expected %0d", start_cyc, rc + 1);
    end
    checks++;
    if (dc !== start_cyc + 4) begin
      errors++;
      $display("FAIL done_latency: got done cycle %0d, expected %0d", dc, start_cyc + 4);
    end
    idle_cycles(5);
    checks++;
    if (start_cnt - s !== 1 || p0_done_cnt - d0 !== 1 || p1_done_cnt - d1 !== 0) begin
      errors++;
      $display("FAIL read_counts: got starts=%0d p0_done=%0d p1_done=%0d, expected 1/1/0",
               start_cnt - s, p0_done_cnt - d0, p1_done_cnt - d1);
    end
  endtask

  task automatic test_single_write();
    int s, d0, d1, dc;
    s = start_cnt; d0 = p0_done_cnt; d1 = p1_done_cnt;
    @(negedge clk);
    drive_req(1'b1, 1'b1, 64'h2000, 32'h12345678, 1'b0, 1'b0, 32'h0BAD_F00D);
    wait_done(dc);
    p1_req = 1'b0;
    idle_cycles(5);
    checks++;
    if (start_cnt - s !== 1 || p0_done_cnt - d0 !== 0 || p1_done_cnt - d1 !== 1) begin
      errors++;
      $display("FAIL write_counts: got starts=%0d p0_done=%0d p1_done=%0d, expected 1/0/1",
               start_cnt - s, p0_done_cnt - d0, p1_done_cnt - d1);
    end
  endtask

  task automatic test_fairness();
    int dc, prev_dc;
    do_reset();
    prev_dc = 0;
    drive_req(1'b0, 1'b0, 64'h100, $urandom, 1'b0, 1'b0, $urandom);
    drive_req(1'b1, 1'b0, 64'h200, $urandom, 1'b0, 1'b0, $urandom);
    for (int i = 0; i < 4; i++) begin
      wait_done(dc);
      if (i > 0) begin
        checks++;
        if (start_cyc !== prev_dc + 2) begin
          errors++;
          $display("FAIL back_to_back: got start cycle %0d, expected %0d", start_cyc, prev_dc + 2);
        end
      end
      prev_dc = dc;
      if (i < 2)
        drive_req(i[0], 1'b0, 64'h300 + 64'(i * 16), $urandom, 1'b0, 1'b0, $urandom);
      else if (i[0]) p1_req = 1'b0;
      else p0_req = 1'b0;
    end
    idle_cycles(4);
  endtask

  task automatic test_faults();
    int dc;
    @(negedge clk);
    drive_req(1'b1, 1'b0, 64'h4000, 32'h0, 1'b0, 1'b1, 32'h1111_2222);
    wait_done(dc);
    p1_req = 1'b0;
    @(negedge clk);
    drive_req(1'b0, 1'b1, 64'h4004, 32'hCAFE_0001, 1'b0, 1'b1, 32'h3333_4444);
    wait_done(dc);
    p0_req = 1'b0;
    @(negedge clk);
    drive_req(1'b0, 1'b1, 64'h4008, 32'hCAFE_0002, 1'b1, 1'b0, 32'h5555_6666);
    wait_done(dc);
    p0_req = 1'b0;
    idle_cycles(3);
  endtask

  task automatic test_reset_mid();
    int s, d0, d1;
    bit hit;
    m_lat = 10;
    @(negedge clk);
    drive_req(1'b0, 1'b0, 64'h8000, 32'h0, 1'b0, 1'b0, 32'h7777_8888);
    hit = 0;
    for (int n = 0; n < 20 && !hit; n++) begin
      @(negedge clk);
      if (dbg_state == WAIT) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reach_wait: got state %0d, expected WAIT within 20 cycles", dbg_state);
    end
    arst = 1'b1;
    p0_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({p0_rdata, p0_done, p0_fault, p1_rdata, p1_done, p1_fault, m_addr, m_data, m_sw, m_sr} !== '0
        || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL mid_reset: got state=%0d m_addr=%h rdata=%h, expected IDLE and all 0",
               dbg_state, m_addr, p0_rdata);
    end
    arst = 1'b0;
    exp_q.delete();
    resp_q.delete();
    s = start_cnt; d0 = p0_done_cnt; d1 = p1_done_cnt;
    @(negedge clk);
    stale_done = 1'b1;
    @(negedge clk);
    stale_done = 1'b0;
    idle_cycles(5);
    checks++;
    if (start_cnt != s || p0_done_cnt != d0 || p1_done_cnt != d1 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL stale_done: got starts=%0d dones=%0d/%0d state=%0d, expected 0/0/0 IDLE",
               start_cnt - s, p0_done_cnt - d0, p1_done_cnt - d1, dbg_state);
    end
    m_lat = 3;
  endtask

  task automatic test_hold_past_done();
    int s, d1, dc;
    s = start_cnt; d1 = p1_done_cnt;
    @(negedge clk);
    drive_req(1'b1, 1'b0, 64'hA000, 32'h0, 1'b0, 1'b0, 32'h9999_AAAA);
    wait_done(dc);
    @(posedge clk);
    #1 p1_req = 1'b0;
    idle_cycles(8);
    checks++;
    if (start_cnt - s !== 1 || p1_done_cnt - d1 !== 1) begin
      errors++;
      $display("FAIL hold_past_done: got starts=%0d dones=%0d, expected 1/1",
               start_cnt - s, p1_done_cnt - d1);
    end
  endtask

  task automatic test_random();
    int dc;
    bit port, we;
    for (int i = 0; i < 8; i++) begin
      m_lat = $urandom_range(1, 6);
      port  = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      @(negedge clk);
      drive_req(port, we, {32'h0, $urandom}, $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom);
      wait_done(dc);
      if (port) p1_req = 1'b0;
      else p0_req = 1'b0;
      idle_cycles($urandom_range(0, 2));
    end
    m_lat = 3;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    arst = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_fairness();
    test_faults();
    test_reset_mid();
    test_hold_past_done();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d pending expected completions, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
